// File: rtl/lane_scheduler.sv
// Four-lane traffic scheduler: grants up to two lanes per green phase with
// rotating priority, starvation override and early green termination.
module lane_scheduler #(
  parameter int unsigned GREEN_CYCLES  = 8,
  parameter int unsigned MIN_GREEN     = 3,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned ALLRED_CYCLES = 1,
  parameter int unsigned MAX_WAIT      = 16,
  parameter int unsigned WAIT_W        = 8
) (
  input  logic       i_clock,
  input  logic       i_resetn,
  input  logic [3:0] i_lanes,
  output logic [3:0] o_green,
  output logic [3:0] o_yellow,
  output logic [3:0] o_red,
  output logic [3:0] o_starved
);

  localparam int unsigned NLANES = 4;
  localparam int unsigned TMAX_GY = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int unsigned TMAX    = (TMAX_GY > ALLRED_CYCLES) ? TMAX_GY : ALLRED_CYCLES;
  localparam int unsigned TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]     AR_LAST = TW'(ALLRED_CYCLES - 1);
  localparam logic [TW-1:0]     G_LAST  = TW'(GREEN_CYCLES - 1);
  localparam logic [TW-1:0]     MG_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0]     Y_LAST  = TW'(YELLOW_CYCLES - 1);
  localparam logic [WAIT_W-1:0] W_MAX   = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_timer;
  logic [1:0]        r_ptr;
  logic [3:0]        r_grant;
  logic [3:0]        r_green;
  logic [3:0]        r_yellow;
  logic [3:0]        r_red;
  logic [3:0]        r_starved;
  logic [WAIT_W-1:0] r_wait     [NLANES];
  logic [WAIT_W-1:0] w_wait_nxt [NLANES];

  logic [3:0] w_sel;
  logic [1:0] w_last_pos;
  logic [1:0] w_cnt;
  logic [1:0] w_lane;
  logic       w_cand;
  logic [1:0] w_ptr_nxt;
  logic       w_early;

  // Two-pass rotating scan: starved requesters first, then the rest; keep the first two.
  always_comb begin
    w_sel      = 4'b0000;
    w_last_pos = 2'd0;
    w_cnt      = 2'd0;
    w_lane     = 2'd0;
    w_cand     = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        w_lane = r_ptr + 2'(k);
        w_cand = i_lanes[w_lane] && (r_starved[w_lane] == 1'(p == 0));
        if (w_cand && (w_cnt < 2'd2)) begin
          w_sel[w_lane] = 1'b1;
          w_cnt         = w_cnt + 2'd1;
          if (2'(k) > w_last_pos) begin
            w_last_pos = 2'(k);
          end
        end
      end
    end
  end

  assign w_ptr_nxt = r_ptr + w_last_pos + 2'd1;

  assign w_early = (r_timer >= MG_LAST) &&
                   (((i_lanes & r_grant) == 4'b0000) || (|(r_starved & ~r_grant)));

  // Phase FSM; lamp outputs are registered alongside the state they decode.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= ST_ALLRED;
      r_timer  <= '0;
      r_ptr    <= 2'd0;
      r_grant  <= 4'b0000;
      r_green  <= 4'b0000;
      r_yellow <= 4'b0000;
      r_red    <= 4'b1111;
    end else begin
      case (r_state)
        ST_ALLRED: begin
          if (r_timer == AR_LAST) begin
            if (|i_lanes) begin
              r_state <= ST_GREEN;
              r_timer <= '0;
              r_grant <= w_sel;
              r_ptr   <= w_ptr_nxt;
              r_green <= w_sel;
              r_red   <= ~w_sel;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_GREEN: begin
          if ((r_timer == G_LAST) || w_early) begin
            r_state  <= ST_YELLOW;
            r_timer  <= '0;
            r_green  <= 4'b0000;
            r_yellow <= r_grant;
            r_red    <= ~r_grant;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_YELLOW: begin
          if (r_timer == Y_LAST) begin
            r_state  <= ST_ALLRED;
            r_timer  <= '0;
            r_yellow <= 4'b0000;
            r_red    <= 4'b1111;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state  <= ST_ALLRED;
          r_timer  <= '0;
          r_green  <= 4'b0000;
          r_yellow <= 4'b0000;
          r_red    <= 4'b1111;
        end
      endcase
    end
  end

  // Per-lane wait counters: clear while green, count while requesting, saturate.
  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      w_wait_nxt[i] = r_wait[i];
      if (r_green[i]) begin
        w_wait_nxt[i] = '0;
      end else if (i_lanes[i] && (r_wait[i] != W_MAX)) begin
        w_wait_nxt[i] = r_wait[i] + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < NLANES; i++) begin
        r_wait[i] <= '0;
      end
      r_starved <= 4'b0000;
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        r_wait[i]    <= w_wait_nxt[i];
        r_starved[i] <= (w_wait_nxt[i] == W_MAX);
      end
    end
  end

  assign o_green   = r_green;
  assign o_yellow  = r_yellow;
  assign o_red     = r_red;
  assign o_starved = r_starved;

endmodule

// File: tb/tb_lane_scheduler.sv
// Self-checking bench for lane_scheduler: table of per-phase expectations
// expanded cycle by cycle through a scoreboard queue, plus an async-reset sequence.
module tb_lane_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] lanes_a, lanes_b;
  logic [3:0] g_a, y_a, r_a, s_a;
  logic [3:0] g_b, y_b, r_b, s_b;

  always #5 clk = ~clk;

  lane_scheduler dut_a (
    .i_clock  (clk),
    .i_resetn (rst_n),
    .i_lanes  (lanes_a),
    .o_green  (g_a),
    .o_yellow (y_a),
    .o_red    (r_a),
    .o_starved(s_a)
  );

  lane_scheduler #(.GREEN_CYCLES(30), .MAX_WAIT(10)) dut_b (
    .i_clock  (clk),
    .i_resetn (rst_n),
    .i_lanes  (lanes_b),
    .o_green  (g_b),
    .o_yellow (y_b),
    .o_red    (r_b),
    .o_starved(s_b)
  );

  typedef struct {
    bit          rst;
    bit          use_b;
    logic [3:0]  lanes;
    int unsigned n;
    logic [3:0]  g;
    logic [3:0]  y;
    logic [3:0]  s;
  } seg_t;

  typedef struct {
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    logic [3:0] s;
  } exp_t;

  seg_t segs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(bit rst, bit use_b, logic [3:0] lanes, int unsigned n,
                              logic [3:0] g, logic [3:0] y, logic [3:0] s);
    seg_t e;
    e.rst = rst; e.use_b = use_b; e.lanes = lanes; e.n = n;
    e.g = g; e.y = y; e.s = s;
    segs.push_back(e);
  endfunction

  task automatic check(string name, bit use_b, exp_t e);
    logic [3:0] ag, ay, ar, as;
    ag = use_b ? g_b : g_a;
    ay = use_b ? y_b : y_a;
    ar = use_b ? r_b : r_a;
    as = use_b ? s_b : s_a;
    n_cmp++;
    if (ag !== e.g || ay !== e.y || ar !== e.r || as !== e.s) begin
      n_bad++;
      $display("FAIL %s: got G=%b Y=%b R=%b S=%b, want G=%b Y=%b R=%b S=%b",
               name, ag, ay, ar, as, e.g, e.y, e.r, e.s);
    end
  endtask

  // One clock cycle: drive lanes, queue the expected lamps, compare after settle.
  task automatic step(string name, bit use_b, logic [3:0] lanes,
                      logic [3:0] g, logic [3:0] y, logic [3:0] s);
    exp_t e;
    if (use_b) lanes_b = lanes; else lanes_a = lanes;
    e.g = g; e.y = y; e.r = ~(g | y); e.s = s;
    exp_q.push_back(e);
    #1;
    check(name, use_b, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    exp_t e;
    e.g = 4'h0; e.y = 4'h0; e.r = 4'hF; e.s = 4'h0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("reset_a", 1'b0, e);
    check("reset_b", 1'b1, e);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    rst_n   = 1'b0;
    lanes_a = 4'h0;
    lanes_b = 4'h0;

    // Idle: nothing requested for 50 cycles.
    add(1, 0, 4'h0, 50, 4'h0, 4'h0, 4'h0);
    // Single lane 0: 1 all-red, then 8 green / 2 yellow / 1 all-red repeating.
    add(1, 0, 4'h1, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 4'h1, 8, 4'h1, 4'h0, 4'h0);
    add(0, 0, 4'h1, 2, 4'h0, 4'h1, 4'h0);
    add(0, 0, 4'h1, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 4'h1, 8, 4'h1, 4'h0, 4'h0);
    add(0, 0, 4'h1, 2, 4'h0, 4'h1, 4'h0);
    add(0, 0, 4'h1, 1, 4'h0, 4'h0, 4'h0);
    // All lanes: pairs alternate 0011 / 1100 with no starvation.
    add(1, 0, 4'hF, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 4'hF, 8, 4'h3, 4'h0, 4'h0);
    add(0, 0, 4'hF, 2, 4'h0, 4'h3, 4'h0);
    add(0, 0, 4'hF, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 4'hF, 8, 4'hC, 4'h0, 4'h0);
    add(0, 0, 4'hF, 2, 4'h0, 4'hC, 4'h0);
    add(0, 0, 4'hF, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 4'hF, 8, 4'h3, 4'h0, 4'h0);
    // Lane 2 withdraws after 2 green cycles: early end at minimum green.
    add(1, 0, 4'h4, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 4'h4, 2, 4'h4, 4'h0, 4'h0);
    add(0, 0, 4'h0, 1, 4'h4, 4'h0, 4'h0);
    add(0, 0, 4'h0, 2, 4'h0, 4'h4, 4'h0);
    add(0, 0, 4'h0, 5, 4'h0, 4'h0, 4'h0);
    // Lanes 1..3: pointer rotation gives 0110, 1010, 1100.
    add(1, 0, 4'hE, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 4'hE, 8, 4'h6, 4'h0, 4'h0);
    add(0, 0, 4'hE, 2, 4'h0, 4'h6, 4'h0);
    add(0, 0, 4'hE, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 4'hE, 8, 4'hA, 4'h0, 4'h0);
    add(0, 0, 4'hE, 2, 4'h0, 4'hA, 4'h0);
    add(0, 0, 4'hE, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 4'hE, 8, 4'hC, 4'h0, 4'h0);
    // Long green with MAX_WAIT=10: starvation cuts green short and wins next grant.
    add(1, 1, 4'hF, 1, 4'h0, 4'h0, 4'h0);
    add(0, 1, 4'hF, 9, 4'h3, 4'h0, 4'h0);
    add(0, 1, 4'hF, 1, 4'h3, 4'h0, 4'hC);
    add(0, 1, 4'hF, 2, 4'h0, 4'h3, 4'hC);
    add(0, 1, 4'hF, 1, 4'h0, 4'h0, 4'hC);
    add(0, 1, 4'hF, 1, 4'hC, 4'h0, 4'hC);
    add(0, 1, 4'hF, 6, 4'hC, 4'h0, 4'h0);
    add(0, 1, 4'hF, 1, 4'hC, 4'h0, 4'h3);
    add(0, 1, 4'hF, 2, 4'h0, 4'hC, 4'h3);
    add(0, 1, 4'hF, 1, 4'h0, 4'h0, 4'h3);
    add(0, 1, 4'hF, 1, 4'h3, 4'h0, 4'h3);

    foreach (segs[i]) begin
      if (segs[i].rst) do_reset();
      for (int c = 0; c < int'(segs[i].n); c++) begin
        step($sformatf("seg%0d_cyc%0d", i, c), segs[i].use_b, segs[i].lanes,
             segs[i].g, segs[i].y, segs[i].s);
      end
    end

    // Reset asserted mid-green: lamps go all-red without a clock edge.
    do_reset();
    step("mid_ar", 0, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 4; c++) step($sformatf("mid_g%0d", c), 0, 4'hF, 4'h3, 4'h0, 4'h0);
    #2;
    rst_n = 1'b0;
    e.g = 4'h0; e.y = 4'h0; e.r = 4'hF; e.s = 4'h0;
    #1;
    check("async_rst", 1'b0, e);
    @(negedge clk);
    #1;
    check("rst_held", 1'b0, e);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_ar", 0, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 8; c++) step($sformatf("post_g%0d", c), 0, 4'hF, 4'h3, 4'h0, 4'h0);
    for (int c = 0; c < 2; c++) step($sformatf("post_y%0d", c), 0, 4'hF, 4'h0, 4'h3, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
